adder_share_arbiter: RTL
========================

# adder_share_arbiter

Round-robin arbiter and sequencer that shares one external `ripple_carry_adder` instance of width `WIDTH` among `NREQ` requesters. It accepts one request at a time over a valid/ready handshake and drives the adder from registered operands. After one settle cycle it captures sum and carry-out, then returns them on a single response channel tagged with the requester index. It sits between the adder datapath and the client blocks that need occasional additions.

## Interface
- `WIDTH`, 4, operand/sum width; must match the shared adder.
- `NREQ`, 4, number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`, width of the response ID (derived; not overridden).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i = requester i has an operation pending.
- `req_a`  in  NREQ*WIDTH  operand A; requester i at `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NREQ*WIDTH  operand B, same packing.
- `req_cin`  in  NREQ  carry-in per requester.
- `req_ready`  out  NREQ  one-hot accept strobe; bit i high = requester i's operands are taken this cycle.
- `add_a`  out  WIDTH  to shared adder `a`; registered.
- `add_b`  out  WIDTH  to shared adder `b`; registered.
- `add_cin`  out  1  to shared adder `cin`; registered.
- `add_sum`  in  WIDTH  from shared adder `sum`.
- `add_cout`  in  1  from shared adder `cout`.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  WIDTH  captured sum.
- `rsp_cout`  out  1  captured carry-out.
- `rsp_ready`  in  1  consumer accepts the response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, grant the winner `g`: `req_ready[g]=1` combinationally in that cycle.
  - On the clock edge, latch `add_a/add_b/add_cin` from slot `g`, store `g` as the owner, and go to EXEC.
  - Otherwise remain in IDLE with `req_ready=0`.
- EXEC: the adder inputs are stable. On the clock edge, capture `add_sum`/`add_cout` into `rsp_sum`/`rsp_cout`, set `rsp_valid=1`, and go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id`, `rsp_sum` and `rsp_cout` stable until `rsp_ready=1`.
  - On the handshake edge, clear `rsp_valid` and go to IDLE.
- `req_ready` is 0 in EXEC and RESP. At most one bit is set at any time.
- Round-robin arbitration:
  - A pointer `p` holds the highest-priority index; the search runs `p, p+1, …` modulo `NREQ`.
  - After a grant to `g`, `p` becomes `(g+1) mod NREQ`, wrapping from `NREQ-1` to 0.
  - Reset sets `p=0`.
- Requesters hold `req_valid` and their operands until they see `req_ready`. Dropping `req_valid` before the grant is legal and causes no grant. Arbitration uses the current cycle's `req_valid` only.
- Arithmetic: `{rsp_cout, rsp_sum} = add_a + add_b + add_cin`, computed by the external adder. The block performs no arithmetic itself and passes the values through unmodified.
- The operand registers keep their last value outside EXEC; they are not cleared after use.
- Reset values: state IDLE; `req_ready=0`, `add_a=0`, `add_b=0`, `add_cin=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`; `p=0`.
- Reset mid-operation, in EXEC or RESP: the in-flight transaction is discarded, no response is produced, and the pointer returns to 0.

## Timing
- Accept edge T (the grant cycle is T-1 → T). The edge ending EXEC (T+1) sets `rsp_valid`, so it is first visible in cycle T+1.
- Latency: 2 cycles from the grant cycle to `rsp_valid` high.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP) when `rsp_ready` is held at 1. The next grant can occur in the cycle after the response handshake.
- `rsp_ready` high in IDLE or EXEC has no effect.
- The adder's combinational path from `add_*` to `add_sum`/`add_cout` must settle within one clock period.

## Test plan
- Reset: assert `rst` for 2 cycles with all `req_valid=1` → all outputs 0, no `req_ready`. After release, the first grant goes to requester 0.
- Single request: requester 2 sends 0011+1010+cin1 (WIDTH=4) → `req_ready=0100` for one cycle. Two cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_sum=1110`, `rsp_cout=0`.
- Carry and full-scale cases:
  - 1001+0110+1 → sum 0000, cout 1.
  - 1010+1100+1 → sum 0111, cout 1.
  - 1111+0000+0 → sum 1111, cout 0.
- Fairness: all four `req_valid` held high with `rsp_ready=1` → grant order 0,1,2,3,0, with consecutive grants exactly 3 cycles apart.
- Backpressure: `rsp_ready=0` for 5 cycles in RESP while other requests are pending → response held stable, `req_ready` stays 0. On release, the handshake completes and the next grant follows in the next cycle.
- Reset mid-EXEC: assert `rst` during EXEC → no `rsp_valid` afterwards, and the pointer restarts at 0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sequencer sharing one external adder among NREQ requesters
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/a/b/cin         per-requester operation request, operands packed at [i*WIDTH +: WIDTH]
//   req_ready                 one-hot accept strobe, combinational in the grant cycle
//   add_a/add_b/add_cin       registered operands driven to the shared adder
//   add_sum/add_cout          result returned by the shared adder
//   rsp_valid/id/sum/cout     response channel, held until rsp_ready
//   rsp_ready                 consumer accepts the response
module adder_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    input  logic                  rsp_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ-1);

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic [WIDTH-1:0] slot_a [NREQ];
    logic [WIDTH-1:0] slot_b [NREQ];
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot_a[i] = req_a[i*WIDTH +: WIDTH];
            slot_b[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Scan p, p+1, ... wrapping at NREQ; the first set req_valid bit wins.
    // cand carries one extra bit so p+k never overflows before the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Masked by rst so no requester believes it was accepted while the
    // reset edge is discarding everything.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    add_a_d   = slot_a[grant_idx];
                    add_b_d   = slot_b[grant_idx];
                    add_cin_d = req_cin[grant_idx];
                    rsp_id_d  = grant_idx;
                    ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for a full cycle; the adder has settled.
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule
